// File: rtl/hilo_multdiv.sv
// hilo_multdiv: multi-cycle unsigned MULTU/DIVU unit owning HI/LO, with MFHI/MFLO read port and hazard stall.
module hilo_multdiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] out
);
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     op_q, op_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d, mul_nxt, div_nxt, step_nxt;
  logic [WIDTH:0]       msum, cand, diff;
  logic                 is_multu, is_divu, is_mf, accept, ge, last;
  always_comb begin
    is_multu = Signal == F_MULTU;
    is_divu  = Signal == F_DIVU;
    is_mf    = (Signal == F_MFHI) | (Signal == F_MFLO);
    busy     = (state_q == MUL) | (state_q == DIV);
    done     = state_q == DONE;
    stall    = start & is_mf & busy;
    hi       = hi_q;
    lo       = lo_q;
    out      = (Signal == F_MFHI) ? hi_q : (Signal == F_MFLO) ? lo_q : '0;
    // acc = {partial product, remaining multiplier bits}; add multiplicand when the low bit is set
    msum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, op_q} : '0);
    mul_nxt  = {msum, acc_q[WIDTH-1:1]};
    // acc = {remainder, dividend bits shifting into quotient}; ge decides restore vs keep
    cand     = acc_q[2*WIDTH-1:WIDTH-1];
    ge       = cand >= {1'b0, op_q};
    diff     = cand - {1'b0, op_q};
    div_nxt  = ge ? {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                  : {cand[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    step_nxt = (state_q == MUL) ? mul_nxt : div_nxt;
    last     = cnt_q == CNT_W'(WIDTH - 1);
    accept   = start & (is_multu | is_divu) & ((state_q == IDLE) | (state_q == DONE));
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      state_d = is_multu ? MUL : DIV;
      cnt_d   = '0;
      op_d    = is_multu ? dataA : dataB;
      acc_d   = {{WIDTH{1'b0}}, is_multu ? dataB : dataA};
    end else if (busy) begin
      acc_d = step_nxt;
      cnt_d = cnt_q + CNT_W'(1);
      if (last) begin
        state_d = DONE;
        hi_d    = step_nxt[2*WIDTH-1:WIDTH];
        lo_d    = step_nxt[WIDTH-1:0];
      end
    end else if (done) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule

// File: tb/tb_hilo_multdiv.sv
// tb_hilo_multdiv: directed vectors against an arithmetic scoreboard model checked every cycle.
module tb_hilo_multdiv;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIVU  = 6'b011011;
  localparam logic [5:0] MFHI  = 6'b010000;
  localparam logic [5:0] MFLO  = 6'b010010;
  logic        clk = 0, reset = 0, start = 0;
  logic [5:0]  Signal = 6'h3f;
  logic [31:0] dataA = 0, dataB = 0;
  logic        busy, done, stall;
  logic [31:0] hi, lo, out;
  int          n_pass = 0, n_total = 0;
  bit          chk_en = 0;
  int          m_left = 0;
  logic        m_done = 0;
  logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
  int          bc;

  hilo_multdiv dut (.clk(clk), .reset(reset), .start(start), .Signal(Signal), .dataA(dataA),
                    .dataB(dataB), .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo), .out(out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    else n_pass++;
  endtask

  // Reference model: a busy countdown plus the arithmetic result computed at accept.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0; m_done <= 0; m_hi <= 0; m_lo <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      m_done <= (m_left == 1);
      if (m_left == 1) begin m_hi <= p_hi; m_lo <= p_lo; end
    end else begin
      m_done <= 0;
      if (start && Signal == MULTU) begin
        m_left <= 32;
        {p_hi, p_lo} <= {32'b0, dataA} * {32'b0, dataB};
      end else if (start && Signal == DIVU) begin
        m_left <= 32;
        p_lo <= (dataB == 0) ? 32'hFFFFFFFF : dataA / dataB;
        p_hi <= (dataB == 0) ? dataA : dataA % dataB;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    logic mf;
    mf = (Signal == MFHI) || (Signal == MFLO);
    chk("busy", busy, m_left > 0);
    chk("done", done, m_done);
    chk("stall", stall, start && mf && m_left > 0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (!(mf && m_left > 0))
      chk("out", out, Signal == MFHI ? m_hi : Signal == MFLO ? m_lo : 32'h0);
  end

  task automatic issue(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1; Signal = sig; dataA = a; dataB = b;
    @(posedge clk); #1;
    start = 0; Signal = 6'h3f; dataA = $urandom; dataB = $urandom;
  endtask

  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (busy) busy_cnt++;
    end
    chk("done_seen", done, 1);
  endtask

  task automatic run_op(input logic [5:0] sig, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    issue(sig, a, b);
    wait_done(bc);
    chk("latency", bc, 32);
    chk("res_hi", hi, eh);
    chk("res_lo", lo, el);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    chk_en = 1;
    @(negedge clk);
    chk("por_busy", busy, 0);
    chk("por_hi", hi, 0);
    run_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    @(negedge clk);
    chk("done_pulse", done, 0);
    run_op(MULTU, 32'h00012345, 32'h00000010, 32'h0, 32'h00123450);
    run_op(DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op(DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
    // hazard: MFHI held while a multiply iterates
    issue(MULTU, 32'h10000, 32'h30000);
    start = 1; Signal = MFHI;
    wait_done(bc);
    chk("hz_lat", bc, 32);
    chk("hz_stall", stall, 0);
    chk("hz_out", out, 32'h3);
    @(posedge clk); #1 start = 0; Signal = 6'h3f;
    // ignored second start at cycle 10
    issue(MULTU, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1 start = 1; Signal = DIVU; dataA = 32'd100; dataB = 32'd7;
    @(posedge clk); #1 start = 0; Signal = 6'h3f;
    wait_done(bc);
    chk("ign_hi", hi, 32'd0);
    chk("ign_lo", lo, 32'd12);
    // new DIVU accepted in the DONE cycle
    start = 1; Signal = DIVU; dataA = 32'd1000; dataB = 32'd10;
    @(posedge clk); #1 start = 0; Signal = 6'h3f;
    wait_done(bc);
    chk("b2b_lat", bc, 32);
    chk("b2b_hi", hi, 32'd0);
    chk("b2b_lo", lo, 32'd100);
    // reset mid-op, between clock edges
    issue(MULTU, 32'd7, 32'd9);
    repeat (14) @(posedge clk);
    #2 reset = 0;
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    @(posedge clk); #1 reset = 1; start = 1; Signal = MFLO;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_out", out, 0);
      chk("post_done", done, 0);
    end
    start = 0; Signal = 6'h3f;
    @(negedge clk);
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/hilo_multdiv.md
Name: hilo_multdiv

Overview:
Multi-cycle unsigned multiply/divide unit in the EX stage, parallel to the barrel shifter. It consumes rs/rt operands and the 6-bit funct code from the ID/EX register. It owns the HI/LO registers and serves MFHI/MFLO reads to the EX result mux. While a MULTU/DIVU is in flight and a dependent MFHI/MFLO arrives, it raises a stall toward the hazard unit.

Parameters:
WIDTH, 32, operand/result width; HI and LO are each WIDTH bits
CNT_W, 5, iteration counter width; must satisfy 2^CNT_W == WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  ID/EX instruction valid; qualifies Signal
Signal  input  6  funct code: MULTU=6'b011001, DIVU=6'b011011, MFHI=6'b010000, MFLO=6'b010010; any other value is no-op
dataA  input  WIDTH  rs operand (multiplicand / dividend)
dataB  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while an operation iterates
done  output  1  one-cycle pulse when HI/LO have just been written
stall  output  1  combinational: start & (Signal==MFHI|MFLO) & busy
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
out  output  WIDTH  combinational: hi if Signal==MFHI, lo if Signal==MFLO, else 0

Behaviour:
- Reset (reset==0, async): state=IDLE, hi=0, lo=0, counter=0, internal operand/accumulator regs=0, busy=0, done=0. An in-flight op is abandoned; HI/LO are not partially written.
- States: IDLE, MUL, DIV, DONE. busy=1 only in MUL/DIV; done=1 only in DONE.
- Accept: in IDLE or DONE, on an edge with start=1 and Signal=MULTU/DIVU, latch dataA/dataB, clear counter, go to MUL/DIV. Start in MUL/DIV with MULTU/DIVU is ignored; the issuing logic must not do this.
- MUL: shift-add, one multiplier bit (LSB first) per edge, 2*WIDTH-bit accumulator. DIV: restoring division, one quotient bit (MSB first) per edge. WIDTH iteration edges total. On the edge where counter==WIDTH-1: write hi/lo, go to DONE.
- Latency: accept edge = E0. busy high from E0 through E32, i.e. 32 cycles. hi/lo updated at E32. done high for the cycle after E32. DONE returns to IDLE at E33 unless a new op is accepted at E33.
- MULTU result: {hi,lo} = dataA*dataB, full 64-bit unsigned.
- DIVU result: lo = quotient, hi = remainder, unsigned. No divide-by-zero special case. Divisor 0 runs the same 32 cycles and yields lo=0xFFFFFFFF, hi=dataA.
- MFHI/MFLO with busy=0: out reflects hi/lo the same cycle. In DONE, this is the new value.
- MFHI/MFLO with busy=1: stall=1 and out must not be used. stall deasserts combinationally in DONE.
- Operands are latched at accept. dataA/dataB changes during iteration have no effect.
- Unknown Signal values: no state change, out=0, stall=0.

Test Plan:
- Reset: assert reset=0 mid-cycle with clk idle -> hi=lo=0, busy=done=stall=0 immediately, no clock required.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy high exactly 32 cycles; done pulses 1 cycle; hi=0xFFFFFFFE, lo=0x00000001. MULTU 0x00012345 x 0x00000010 -> hi=0, lo=0x00123450.
- DIVU 100 / 7 -> lo=14, hi=2 at done. DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, same 32-cycle latency.
- Hazard: MFHI presented while busy -> stall=1 every busy cycle; stall=0 in DONE with out = new hi.
- Back-to-back and ignore: MULTU 3x4 with a DIVU start at cycle 10 -> second start ignored, result hi=0, lo=12. DIVU accepted during the DONE cycle -> begins immediately, done 33 cycles later.
- Reset mid-op: MULTU 7x9, reset=0 at cycle 15 -> hi=lo=0, state IDLE. After release, MFLO -> out=0 and no spurious done.
